psg_rr_bus_arb: RTL and testbench

//  Round-robin bus arbiter/sequencer for the shared PSG wave-table/register bus.
//  Up to NREQ voice/DMA/CPU requesters compete; one owner holds the bus until ack.

---
 rtl/psg_rr_bus_arb.sv | 140 ++++++++++++++
 tb/tb_psg_rr_bus_arb.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/psg_rr_bus_arb.sv
// Round-robin owner arbiter for the shared PSG wave-table/register bus.
// Optional owner watchdog is built when PSG_ARB_WATCHDOG_EN is defined.
//
//   state | meaning
//   IDLE  | no owner, grant=0, waiting for any req
//   OWN   | grant holds one owner until ack, req drop or watchdog release
module psg_rr_bus_arb #(
  parameter int NREQ       = 8,
  parameter int SELW       = 3,
  parameter int TMO_CYCLES = 255,
  parameter int TMOW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [NREQ-1:0] req,
  input  logic            ack,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] seln,
  output logic            cyc,
  output logic            tmo
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [SELW-1:0] seln_n, last, last_n;
  logic [NREQ-1:0] cand;
  logic [SELW-1:0] base, win, hi_win, lo_win;
  logic            hi_vld, lo_vld, win_vld;
  logic            owner_req, rel, wd_exp;

  assign cyc       = |grant;
  assign owner_req = |(req & grant);
  assign rel       = ack | ~owner_req | wd_exp;

  // The releasing owner is masked out so it cannot be regranted immediately.
  assign cand = (state == OWN) ? (req & ~grant) : req;
  assign base = (state == OWN) ? seln : last;

  // Two-pass search: indices above base first, then wrap to 0..base.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_win = '0;
    lo_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (cand[k] && (k > int'(base)) && !hi_vld) begin
        hi_vld = 1'b1;
        hi_win = SELW'(k);
      end
      if (cand[k] && (k <= int'(base)) && !lo_vld) begin
        lo_vld = 1'b1;
        lo_win = SELW'(k);
      end
    end
  end

  assign win_vld = hi_vld | lo_vld;
  assign win     = hi_vld ? hi_win : lo_win;

  always_comb begin
    state_n = state;
    grant_n = grant;
    seln_n  = seln;
    last_n  = last;
    if (ce) begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_n = NREQ'(1) << win;
            seln_n  = win;
            state_n = OWN;
          end
        end
        OWN: begin
          if (rel) begin
            last_n = seln;
            if (win_vld) begin
              grant_n = NREQ'(1) << win;
              seln_n  = win;
            end else begin
              grant_n = '0;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      seln  <= '0;
      last  <= SELW'(NREQ - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      seln  <= seln_n;
      last  <= last_n;
    end
  end

`ifdef PSG_ARB_WATCHDOG_EN
  logic [TMOW-1:0] wdog, wdog_n;
  logic            tmo_n;

  // ack on the expiry cycle is a normal release, so it suppresses the timeout.
  assign wd_exp = (state == OWN) && (wdog == TMOW'(TMO_CYCLES)) && !ack;
  assign tmo_n  = ce && wd_exp;

  always_comb begin
    wdog_n = wdog;
    if (ce) begin
      if ((state == IDLE) || rel) wdog_n = '0;
      else if (wdog != '1)        wdog_n = wdog + 1'b1;
    end
  end

  // tmo clears on the following clk regardless of ce so it is a single-clk pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
      tmo  <= 1'b0;
    end else begin
      wdog <= wdog_n;
      tmo  <= tmo_n;
    end
  end
`else
  localparam int unused_tmo_cfg = TMO_CYCLES + TMOW;
  assign wd_exp = 1'b0;
  assign tmo    = 1'b0;
`endif

endmodule

// File: tb/tb_psg_rr_bus_arb.sv
// Directed bench for psg_rr_bus_arb (NREQ=8, TMO_CYCLES=4).
// Watchdog expectations follow PSG_ARB_WATCHDOG_EN.
module tb_psg_rr_bus_arb;

  logic       clk, rst, ce, ack;
  logic [7:0] req, grant;
  logic [2:0] seln;
  logic       cyc, tmo;
  int         nvec = 0;
  int         nerr = 0;

  psg_rr_bus_arb #(.NREQ(8), .SELW(3), .TMO_CYCLES(4), .TMOW(3)) dut (
    .clk(clk), .rst(rst), .ce(ce), .req(req), .ack(ack),
    .grant(grant), .seln(seln), .cyc(cyc), .tmo(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [7:0] g, input logic [2:0] s);
    chk({tag, ".grant"}, 16'(grant), 16'(g));
    chk({tag, ".seln"},  16'(seln),  16'(s));
    chk({tag, ".cyc"},   16'(cyc),   16'(g != 8'h00));
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; req = '0; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] g;
    rst = 1'b1; ce = 1'b1; req = '0; ack = 1'b0;

    // 1: full rotation with all requesters active
    do_reset();
    chk_bus("rst", 8'h00, 3'd0);
    chk("rst.tmo", 16'(tmo), 16'h0);
    req = 8'hFF;
    tick();
    chk_bus("rr0", 8'h01, 3'd0);
    ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      g = 8'h01 << (k % 8);
      chk_bus($sformatf("rr%0d", k), g, 3'(k % 8));
    end
    ack = 1'b0; req = 8'h00;
    tick();
    chk_bus("rr_idle", 8'h00, 3'd0);

    // 2: fairness between 0 and 2, then lone-requester idle gap
    do_reset();
    req = 8'h05;
    tick();
    chk_bus("f.first", 8'h01, 3'd0);
    ack = 1'b1;
    tick();
    chk_bus("f.to2", 8'h04, 3'd2);
    ack = 1'b0;
    tick();
    chk_bus("f.hold2", 8'h04, 3'd2);
    ack = 1'b1;
    tick();
    chk_bus("f.back0", 8'h01, 3'd0);
    req = 8'h01;
    tick();
    chk_bus("f.lone_idle", 8'h00, 3'd0);
    ack = 1'b0;
    tick();
    chk_bus("f.lone_regrant", 8'h01, 3'd0);

    // 3: ce 1-in-4; ack with ce=0 ignored
    do_reset();
    req = 8'h08; ce = 1'b0;
    repeat (3) tick();
    chk_bus("ce.no_grant", 8'h00, 3'd0);
    ce = 1'b1;
    tick();
    chk_bus("ce.grant", 8'h08, 3'd3);
    ce = 1'b0; ack = 1'b1;
    repeat (3) tick();
    chk_bus("ce.ack_ignored", 8'h08, 3'd3);
    ce = 1'b1;
    tick();
    chk_bus("ce.ack_taken", 8'h00, 3'd3);

    // 4: owner abandons, waiting requester takes over
    do_reset();
    req = 8'h20;
    tick();
    chk_bus("ab.own5", 8'h20, 3'd5);
    req = 8'h60;
    tick();
    chk_bus("ab.hold5", 8'h20, 3'd5);
    req = 8'h40;
    tick();
    chk_bus("ab.to6", 8'h40, 3'd6);
    chk("ab.tmo", 16'(tmo), 16'h0);

    // 5: watchdog
    do_reset();
    req = 8'h02;
    tick();
    chk_bus("wd.own1", 8'h02, 3'd1);
    req = 8'h06;
    repeat (4) tick();
    chk_bus("wd.pre", 8'h02, 3'd1);
    chk("wd.pre_tmo", 16'(tmo), 16'h0);
    tick();
`ifdef PSG_ARB_WATCHDOG_EN
    chk_bus("wd.expire", 8'h04, 3'd2);
    chk("wd.tmo_pulse", 16'(tmo), 16'h1);
    tick();
    chk("wd.tmo_clear", 16'(tmo), 16'h0);
    repeat (3) tick();
    ack = 1'b1;
    tick();
    chk_bus("wd.ack_wins", 8'h02, 3'd1);
    chk("wd.ack_tmo", 16'(tmo), 16'h0);
    ack = 1'b0;
`else
    chk_bus("wd.nowd", 8'h02, 3'd1);
    chk("wd.nowd_tmo", 16'(tmo), 16'h0);
    repeat (4) tick();
    chk_bus("wd.nowd_long", 8'h02, 3'd1);
`endif

    // 6: reset mid-transfer with ce low
    do_reset();
    req = 8'h10;
    tick();
    chk_bus("mr.own4", 8'h10, 3'd4);
    req = 8'h13; rst = 1'b1; ce = 1'b0;
    tick();
    chk_bus("mr.reset", 8'h00, 3'd0);
    chk("mr.tmo", 16'(tmo), 16'h0);
    rst = 1'b0; ce = 1'b1;
    tick();
    chk_bus("mr.first", 8'h01, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
